// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser: parses SYNC,CMD,LEN,payload,CHK frames from a UART byte stream.
module uart_pkt_parser #(
  parameter int       TIMEOUT = 100000,
  parameter bit [7:0] SYNC    = 8'hA5
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_fDone,
  input  logic [7:0]  i_Data,
  output logic        o_fValid,
  output logic [7:0]  o_Cmd,
  output logic [3:0]  o_Len,
  output logic [63:0] o_Payload,
  output logic        o_fErr,
  output logic [1:0]  o_ErrCode
);
  localparam int IW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CMD, LEN, PAY, CHK} state_t;
  state_t state, state_n;
  logic [IW-1:0] idle;
  logic [2:0]    cnt;
  logic [3:0]    len_w;
  logic [7:0]    cmd_w, x;
  logic [63:0]   pay_w;
  logic          ok_n, err_n;
  logic [1:0]    code_n;
  always_ff @(posedge i_Clk or negedge i_Rst)
    if (!i_Rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    code_n  = o_ErrCode;
    if (i_fDone)
      case (state)
        IDLE: state_n = (i_Data == SYNC) ? CMD : IDLE;
        CMD:  state_n = LEN;
        LEN: begin
          state_n = (i_Data > 8'd8) ? IDLE : (i_Data == 8'd0) ? CHK : PAY;
          err_n   = i_Data > 8'd8;
          code_n  = (i_Data > 8'd8) ? 2'd2 : o_ErrCode;
        end
        PAY:  state_n = ({1'b0, cnt} == len_w - 4'd1) ? CHK : PAY;
        CHK: begin
          state_n = IDLE;
          ok_n    = i_Data == x;
          err_n   = i_Data != x;
          code_n  = (i_Data != x) ? 2'd1 : o_ErrCode;
        end
        default: state_n = IDLE;
      endcase
    else if (state != IDLE && idle == IW'(TIMEOUT - 1)) begin
      state_n = IDLE;
      err_n   = 1'b1;
      code_n  = 2'd3;
    end
  end
  always_ff @(posedge i_Clk or negedge i_Rst)
    if (!i_Rst) begin
      idle      <= '0;
      cnt       <= '0;
      len_w     <= '0;
      cmd_w     <= '0;
      x         <= '0;
      pay_w     <= '0;
      o_fValid  <= 1'b0;
      o_fErr    <= 1'b0;
      o_ErrCode <= '0;
      o_Cmd     <= '0;
      o_Len     <= '0;
      o_Payload <= '0;
    end else begin
      o_fValid  <= ok_n;
      o_fErr    <= err_n;
      o_ErrCode <= code_n;
      idle      <= (i_fDone || state_n == IDLE) ? '0 : idle + 1'b1;
      if (i_fDone)
        case (state)
          IDLE: if (i_Data == SYNC) pay_w <= '0;
          CMD: begin
            cmd_w <= i_Data;
            x     <= i_Data;
          end
          LEN: begin
            len_w <= i_Data[3:0];
            x     <= x ^ i_Data;
            cnt   <= '0;
          end
          PAY: begin
            pay_w[{cnt, 3'b000} +: 8] <= i_Data;
            x   <= x ^ i_Data;
            cnt <= cnt + 1'b1;
          end
          default: ;
        endcase
      if (ok_n) begin
        o_Cmd     <= cmd_w;
        o_Len     <= len_w;
        o_Payload <= pay_w;
      end
    end
endmodule

// File: doc/uart_pkt_parser.md
UART_PKT_PARSER -- requirements
Module: uart_pkt_parser

Interface
REQ-001: The block SHALL have parameter TIMEOUT, default 100000; the maximum number of idle clock cycles allowed between bytes inside a frame.
REQ-002: The block SHALL have parameter SYNC, default 8'hA5; the frame start byte.
REQ-003: The block SHALL have port i_Clk, input, 1 bit; the single clock. All state SHALL update on its rising edge.
REQ-004: The block SHALL have port i_Rst, input, 1 bit; asynchronous, active-low reset.
REQ-005: The block SHALL have port i_fDone, input, 1 bit; one-cycle strobe from the UART receiver meaning a byte is valid.
REQ-006: The block SHALL have port i_Data, input, 8 bits; the received byte, valid when i_fDone=1.
REQ-007: The block SHALL have port o_fValid, output, 1 bit; one-cycle pulse when a good frame has been accepted.
REQ-008: The block SHALL have port o_Cmd, output, 8 bits; the command byte of the last good frame.
REQ-009: The block SHALL have port o_Len, output, 4 bits; the payload length of the last good frame (0..8).
REQ-010: The block SHALL have port o_Payload, output, 64 bits; the payload of the last good frame. Payload byte k SHALL sit at [8k+7:8k], and unused bytes SHALL be 0.
REQ-011: The block SHALL have port o_fErr, output, 1 bit; one-cycle pulse when a frame is aborted.
REQ-012: The block SHALL have port o_ErrCode, output, 2 bits; the cause of the last abort: 1=checksum, 2=length, 3=timeout. It SHALL be held until the next abort.

Function
REQ-013: Frame format SHALL be SYNC, CMD, LEN, LEN payload bytes, CHK, where CHK = CMD ^ LEN ^ every payload byte.
REQ-014: The FSM SHALL have five states: IDLE, CMD, LEN, PAY, CHK.
REQ-015: Each cycle with i_fDone=1 SHALL consume exactly one byte. Cycles with i_fDone=0 SHALL consume nothing.
REQ-016: IDLE: a byte equal to SYNC SHALL move the FSM to CMD. Any other byte SHALL be ignored silently, with no error.
REQ-017: CMD: the byte SHALL be stored as the working command and loaded into the running XOR; next state LEN.
REQ-018: LEN: a byte > 8 SHALL produce o_fErr with code 2 and return to IDLE. A byte of 0 SHALL go to CHK. Otherwise the FSM SHALL go to PAY, with the byte counter cleared.
REQ-019: PAY: the byte SHALL be stored in working payload slot [counter] and XORed into the running checksum. After the LEN-th byte the FSM SHALL go to CHK.
REQ-020: CHK: if the byte equals the running XOR, the block SHALL register o_Cmd, o_Len and o_Payload and pulse o_fValid. Otherwise it SHALL pulse o_fErr with code 1. The next state SHALL be IDLE in both cases.
REQ-021: o_fValid and o_fErr SHALL assert in the cycle after the edge that samples the final byte. Latency SHALL be 1 clock.
REQ-022: The working payload SHALL be cleared on entry to CMD so that short frames leave the upper bytes 0.
REQ-023: Output registers o_Cmd, o_Len and o_Payload SHALL change only on a good frame. Bad frames SHALL leave them unchanged.
REQ-024: Timeout: in any state other than IDLE, an idle counter SHALL increment every cycle without a byte and clear on each byte. When it reaches TIMEOUT, the block SHALL pulse o_fErr with code 3 and return to IDLE.
REQ-025: If a byte and the timeout coincide in the same cycle, the byte SHALL win and the counter SHALL clear.
REQ-026: A SYNC byte received mid-frame SHALL be treated as data and SHALL NOT restart the frame.
REQ-027: o_fValid and o_fErr SHALL never assert in the same cycle.
REQ-028: A new SYNC byte SHALL be accepted in the cycle immediately following a CHK byte, with no dead cycle.

Reset
REQ-029: While i_Rst=0, the block SHALL immediately force state=IDLE, o_fValid=0, o_fErr=0, o_ErrCode=0, o_Cmd=0, o_Len=0, o_Payload=0, and clear all counters and the working XOR/payload.
REQ-030: Reset asserted mid-frame SHALL discard the partial frame. After release the FSM SHALL start in IDLE and wait for SYNC.
REQ-031: Reset release SHALL take effect on the first following i_Clk rising edge.

Verification
REQ-032: Byte sequence A5 12 02 34 56 72 -> one o_fValid pulse with o_Cmd=12, o_Len=2, o_Payload=64'h0000_0000_0000_5634, and o_fErr=0.
REQ-033: Byte sequence A5 12 02 34 56 73 -> o_fErr pulse with o_ErrCode=1. Outputs SHALL keep their previous values.
REQ-034: Byte sequence 00 FF A5 07 09 -> o_fErr with o_ErrCode=2 after byte 09. The bytes 00 and FF SHALL produce no reaction.
REQ-035: Byte sequence A5 40 00 40 -> o_fValid with o_Len=0 and o_Payload=0. Then, with TIMEOUT=16: A5 40 followed by 16 idle cycles -> o_fErr with o_ErrCode=3 in the 17th cycle.
REQ-036: Reset pulsed after A5 12 02 34, then A5 12 02 34 56 72 sent -> exactly one o_fValid, with the REQ-032 values.
